// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the two-road intersection controller.
// NIGHT_FLASH is reachable only when TRAFFIC_NIGHT_FLASH_EN is defined.
package traffic_pkg;

    typedef enum logic [2:0] {
        AR_TO_MAIN  = 3'd0,
        MAIN_GREEN  = 3'd1,
        MAIN_YELLOW = 3'd2,
        AR_TO_SIDE  = 3'd3,
        SIDE_GREEN  = 3'd4,
        SIDE_YELLOW = 3'd5,
        NIGHT_FLASH = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_RED    = 3'b001;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b100;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter advanced only on tick; expire flags a tick seen at zero.
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    // A timer parked at zero keeps expiring on every tick; the FSM decides whether to leave.
    assign expire = tick && (count == '0);

endmodule

// File: rtl/traffic_ctrl_2way.sv
// Two-road intersection controller with all-red clearance and pedestrian walk phase.
// Optional night flashing mode is built in when TRAFFIC_NIGHT_FLASH_EN is defined.
module traffic_ctrl_2way
    import traffic_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int MAIN_GREEN_T = 8,
    parameter int SIDE_GREEN_T = 5,
    parameter int YELLOW_T     = 3,
    parameter int ALLRED_T     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       side_req,
    input  logic       ped_req,
`ifdef TRAFFIC_NIGHT_FLASH_EN
    input  logic       night,
`endif
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] LD_AR = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] LD_MG = CNT_W'(MAIN_GREEN_T - 1);
    localparam logic [CNT_W-1:0] LD_SG = CNT_W'(SIDE_GREEN_T - 1);
    localparam logic [CNT_W-1:0] LD_Y  = CNT_W'(YELLOW_T - 1);

    state_t           state_q;
    state_t           state_d;
    logic             expire;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] count;
    logic             ped_pending;
    logic             enter_side;
    logic             night_i;
    logic             in_night;
    logic             blink;

`ifdef TRAFFIC_NIGHT_FLASH_EN
    assign night_i  = night;
    assign in_night = (state_q == NIGHT_FLASH);
`else
    assign night_i  = 1'b0;
    assign in_night = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] load_for(input state_t s);
        case (s)
            AR_TO_MAIN, AR_TO_SIDE:   return LD_AR;
            MAIN_GREEN:               return LD_MG;
            SIDE_GREEN:               return LD_SG;
            MAIN_YELLOW, SIDE_YELLOW: return LD_Y;
            default:                  return '0;
        endcase
    endfunction

    // Every state change reloads the timer with the new phase's duration.
    assign load     = (state_d != state_q);
    assign load_val = load_for(state_d);

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (LD_AR)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .expire   (expire),
        .count    (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= AR_TO_MAIN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            AR_TO_MAIN:  if (expire) state_d = night_i ? NIGHT_FLASH : MAIN_GREEN;
            // Main green only yields when someone is waiting (or night mode wants the road).
            MAIN_GREEN:  if (expire && (side_req || ped_pending || night_i)) state_d = MAIN_YELLOW;
            MAIN_YELLOW: if (expire) state_d = night_i ? NIGHT_FLASH : AR_TO_SIDE;
            AR_TO_SIDE:  if (expire) state_d = night_i ? NIGHT_FLASH : SIDE_GREEN;
            SIDE_GREEN:  if (expire) state_d = night_i ? NIGHT_FLASH : SIDE_YELLOW;
            SIDE_YELLOW: if (expire) state_d = night_i ? NIGHT_FLASH : AR_TO_MAIN;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            NIGHT_FLASH: if (tick && !night_i) state_d = AR_TO_MAIN;
`endif
            default:     state_d = AR_TO_MAIN;
        endcase
    end

    always_comb begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
        case (state_q)
            MAIN_GREEN:  main_light = LAMP_GREEN;
            MAIN_YELLOW: main_light = LAMP_YELLOW;
            SIDE_GREEN:  side_light = LAMP_GREEN;
            SIDE_YELLOW: side_light = LAMP_YELLOW;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            NIGHT_FLASH: begin
                main_light = blink ? LAMP_YELLOW : LAMP_OFF;
                side_light = blink ? LAMP_RED : LAMP_OFF;
            end
`endif
            default: ;
        endcase
    end

    assign phase      = state_q;
    assign enter_side = (state_d == SIDE_GREEN) && (state_q != SIDE_GREEN);

    // A request landing on the serving edge wins over the clear and waits for the next side phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pending <= 1'b0;
            walk        <= 1'b0;
            ped_ack     <= 1'b0;
        end else begin
            ped_ack <= enter_side && ped_pending;
            if (enter_side && ped_pending) begin
                walk <= 1'b1;
            end else if (state_d != SIDE_GREEN) begin
                walk <= 1'b0;
            end
            if (in_night) begin
                ped_pending <= 1'b0;
            end else if (ped_req) begin
                ped_pending <= 1'b1;
            end else if (enter_side) begin
                ped_pending <= 1'b0;
            end
        end
    end

`ifdef TRAFFIC_NIGHT_FLASH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink <= 1'b0;
        end else if (in_night) begin
            if (tick) blink <= ~blink;
        end else begin
            blink <= 1'b0;
        end
    end
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_ctrl_2way.sv
// Self-checking bench for traffic_ctrl_2way: directed scenarios plus random traffic
// compared cycle by cycle against a phase/ticks-remaining reference model.
module tb_traffic_ctrl_2way;

    localparam int MG  = 8;
    localparam int SG  = 5;
    localparam int YT  = 3;
    localparam int ART = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b1;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    logic       night = 1'b0;
`endif
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: phase number, ticks still to spend in it, pending request, walk, ack.
    int m_ph;
    int m_left;
    bit m_pend;
    bit m_walk;
    bit m_ack;
    int dur[6] = '{ART, MG, YT, ART, SG, YT};

    always #5 clk = ~clk;

    traffic_ctrl_2way dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .side_req   (side_req),
        .ped_req    (ped_req),
`ifdef TRAFFIC_NIGHT_FLASH_EN
        .night      (night),
`endif
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .ped_ack    (ped_ack),
        .phase      (phase)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_main(input int ph);
        if (ph == 1) return 2;
        if (ph == 2) return 4;
        return 1;
    endfunction

    function automatic int exp_side(input int ph);
        if (ph == 4) return 2;
        if (ph == 5) return 4;
        return 1;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_left = ART; m_pend = 0; m_walk = 0; m_ack = 0;
    endtask

    task automatic model_clock(input bit t, input bit s, input bit p);
        int nx;
        bit old_pend;
        old_pend = m_pend;
        m_ack = 0;
        if (t) begin
            if (m_left > 1) begin
                m_left--;
            end else begin
                case (m_ph)
                    0: nx = 1;
                    1: nx = (s || old_pend) ? 2 : 1;
                    2: nx = 3;
                    3: nx = 4;
                    4: nx = 5;
                    default: nx = 0;
                endcase
                if (nx != m_ph) begin
                    if (m_ph == 4) m_walk = 0;
                    if (nx == 4 && old_pend) begin
                        m_walk = 1; m_ack = 1; m_pend = 0;
                    end
                    m_ph = nx;
                    m_left = dur[nx];
                end
            end
        end
        if (p) m_pend = 1;
    endtask

    task automatic check_all();
        chk("phase", 32'(phase), m_ph);
        chk("main_light", 32'(main_light), exp_main(m_ph));
        chk("side_light", 32'(side_light), exp_side(m_ph));
        chk("walk", 32'(walk), 32'(m_walk));
        chk("ped_ack", 32'(ped_ack), 32'(m_ack));
        chk("roads_exclusive", 32'((main_light != 3'b001) && (side_light != 3'b001)), 0);
        chk("lamps_onehot", 32'($onehot(main_light) && $onehot(side_light)), 1);
    endtask

    task automatic step(input bit t, input bit s, input bit p);
        tick = t; side_req = s; ped_req = p;
        @(posedge clk);
        model_clock(t, s, p);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b1; side_req = 1'b0; ped_req = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst = 1'b0;
    endtask

    int run_ph_q[$];
    int run_len_q[$];
    int exp_q[$];
    int cur, run, walk_cnt, ack_cnt, ack_ph, guard;

    initial begin
        // Idle: all-red then main green held with no demand.
        do_reset();
        for (int i = 0; i < 60; i++) step(1, 0, 0);
        chk("idle_main_green", 32'(phase), 1);
        chk("idle_side_red", 32'(side_light), 3'b001);

        // Continuous side demand: record run lengths of each phase.
        do_reset();
        cur = 0; run = 0;
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 0);
            if (int'(phase) == cur) run++;
            else begin
                run_ph_q.push_back(cur); run_len_q.push_back(run);
                cur = int'(phase); run = 1;
            end
        end
        run_ph_q.push_back(cur);
        // First all-red run excludes the reset cycle itself.
        exp_q = '{0, 1, 2, 3, 4, 5, 0, 1};
        chk("seq_runs_count", 32'(run_ph_q.size() >= 8), 1);
        if (run_ph_q.size() >= 8) begin
            for (int i = 0; i < 8; i++) chk($sformatf("seq_phase[%0d]", i), run_ph_q[i], exp_q[i]);
            exp_q = '{1, MG, YT, ART, SG, YT, ART};
            for (int i = 0; i < 7; i++) chk($sformatf("seq_len[%0d]", i), run_len_q[i], exp_q[i]);
        end

        // Pedestrian pulse on cycle 4 with no vehicle demand.
        do_reset();
        walk_cnt = 0; ack_cnt = 0; ack_ph = -1;
        for (int i = 1; i <= 45; i++) begin
            step(1, 0, i == 4);
            if (walk) walk_cnt++;
            if (ped_ack) begin ack_cnt++; ack_ph = int'(phase); end
        end
        chk("walk_cycles", walk_cnt, SG);
        chk("ack_pulses", ack_cnt, 1);
        chk("ack_in_side_green", ack_ph, 4);
        chk("ped_back_to_main", 32'(phase), 1);

        // Sparse tick: every 4th cycle, with side demand and a pedestrian.
        do_reset();
        for (int i = 0; i < 200; i++) step((i % 4) == 3, 1, i == 10);

        // Asynchronous reset in the middle of side green with walk lit.
        do_reset();
        guard = 0;
        step(1, 1, 1);
        while (phase != 3'd4 && guard < 100) begin step(1, 1, 0); guard++; end
        chk("reach_side_green", 32'(phase), 4);
        step(1, 1, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_main_red", 32'(main_light), 3'b001);
        chk("async_side_red", 32'(side_light), 3'b001);
        chk("async_walk_off", 32'(walk), 0);
        chk("async_phase", 32'(phase), 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 30; i++) step(1, 1, 0);

        // Random traffic with random tick gaps.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
